serial_frame_tx: RTL

//   Transmit side of the single-wire serial frame protocol: serialises one parallel word into a frame.

---
 rtl/serial_frame_tx_if.sv | 14 +
 rtl/serial_frame_tx.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
// Word handshake and serial-line signals between an upstream source and serial_frame_tx.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output in_valid, in_data, input in_ready, tx, busy, done);
    modport slave  (input in_valid, in_data, output in_ready, tx, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional odd parity, stop bit.
// Define SERIAL_TX_PARITY_EN to include the odd-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | odd parity bit (only with SERIAL_TX_PARITY_EN)
// STOP   | stop bit (1)
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input logic             clk,
    input logic             resetn,
    serial_frame_tx_if.slave bus
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(DATA_W) + 1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nx;
    logic [CW-1:0]     cyc;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              done_q;
    logic              tx_c;
    logic              bit_end;
    logic              last_bit;
    logic              accept;
`ifdef SERIAL_TX_PARITY_EN
    logic              par;
`endif

    assign bit_end  = (cyc == CW'(BIT_CYCLES - 1));
    assign last_bit = (bit_cnt == BW'(DATA_W - 1));
    assign accept   = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // tx is decoded from registered state only, so reset forces it high without waiting for an edge
    always_comb begin
        state_nx = state;
        tx_c     = 1'b1;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nx = START;
            end
            START: begin
                tx_c = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                tx_c = shreg[0];
`ifdef SERIAL_TX_PARITY_EN
                if (bit_end && last_bit) state_nx = PARITY;
`else
                if (bit_end && last_bit) state_nx = STOP;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                tx_c = par;
                if (bit_end) state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done_q <= (state == STOP) && bit_end;
            if (state == IDLE) begin
                cyc     <= '0;
                bit_cnt <= '0;
                if (accept) begin
                    shreg <= bus.in_data;
`ifdef SERIAL_TX_PARITY_EN
                    par   <= ~^bus.in_data;
`endif
                end
            end else begin
                cyc <= bit_end ? '0 : cyc + 1'b1;
                if ((state == DATA) && bit_end) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tx       = tx_c;
    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
endmodule
